// File: rtl/majority_vote_collector.sv
// Majority vote collector: gathers up to five votes (voter ids 1..5), presents
// the registered vote vector to an external 5-input majority circuit, captures
// its answer and holds it until the consumer takes it. Evaluation is forced
// after TIMEOUT collect cycles if not every voter has reported.
module majority_vote_collector #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vote_valid,
   input  logic [2:0] vote_id,
   input  logic       vote_val,
   output logic       vote_ready,
   output logic [4:0] x,
   input  logic       maj_z,
   output logic       result_valid,
   output logic       result,
   input  logic       result_ready,
   output logic       timed_out,
   output logic       dup_err,
   output logic       id_err
);

   typedef enum logic [1:0] {IDLE, COLLECT, EVAL, HOLD} state_t;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [4:0] mask;
   logic [7:0] timer;

   logic       accept;
   logic       id_legal;
   logic [4:0] id_bit;
   logic       is_new;
   logic       is_dup;
   logic [4:0] mask_next;
   logic [4:0] x_next;

   // One-hot voter select for a legal id; zero for ids 0, 6 and 7.
   function automatic logic [4:0] voter_bit(input logic [2:0] id);
      logic [4:0] b;
      b = 5'b00000;
      if (id >= 3'd1 && id <= 3'd5) b = 5'b00001 << (id - 3'd1);
      return b;
   endfunction

   // Decode the offered vote and build the would-be vote vector and mask.
   always_comb begin
      accept    = vote_valid && vote_ready;
      id_bit    = voter_bit(vote_id);
      id_legal  = (id_bit != 5'b00000);
      is_new    = accept && id_legal && ((mask & id_bit) == 5'b00000);
      is_dup    = accept && id_legal && ((mask & id_bit) != 5'b00000);
      mask_next = mask;
      x_next    = x;
      if (is_new) begin
         mask_next = mask | id_bit;
         x_next    = (x & ~id_bit) | (vote_val ? id_bit : 5'b00000);
      end
   end

   // Collector FSM with all outputs registered. Completion is judged on the
   // registered mask, so the fifth vote always costs one extra COLLECT cycle;
   // the timeout test looks at the post-vote mask so a fifth vote arriving on
   // the last timer cycle still counts as a complete, non-timed-out round.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         x            <= 5'b00000;
         mask         <= 5'b00000;
         timer        <= 8'd0;
         result       <= 1'b0;
         result_valid <= 1'b0;
         timed_out    <= 1'b0;
         dup_err      <= 1'b0;
         id_err       <= 1'b0;
         vote_ready   <= 1'b1;
      end else begin
         dup_err <= is_dup;
         id_err  <= accept && !id_legal;
         case (state)
            IDLE: begin
               if (is_new) begin
                  x     <= x_next;
                  mask  <= mask_next;
                  timer <= 8'd0;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               x    <= x_next;
               mask <= mask_next;
               if (mask == 5'b11111) begin
                  timed_out  <= 1'b0;
                  vote_ready <= 1'b0;
                  state      <= EVAL;
               end else if (timer == TIMER_LAST && mask_next != 5'b11111) begin
                  timed_out  <= 1'b1;
                  vote_ready <= 1'b0;
                  state      <= EVAL;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            EVAL: begin
               result       <= maj_z;
               result_valid <= 1'b1;
               state        <= HOLD;
            end
            HOLD: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  x            <= 5'b00000;
                  mask         <= 5'b00000;
                  timed_out    <= 1'b0;
                  vote_ready   <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_majority_vote_collector.sv
// Bench for majority_vote_collector: a vector table for the main flows plus
// hand-written timeout sequences. The majority circuit is modelled here.
module tb_majority_vote_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vote_valid = 1'b0;
   logic [2:0] vote_id = 3'd0;
   logic       vote_val = 1'b0;
   logic       vote_ready;
   logic [4:0] x;
   logic       maj_z;
   logic       result_valid;
   logic       result;
   logic       result_ready = 1'b0;
   logic       timed_out;
   logic       dup_err;
   logic       id_err;

   int n_total = 0;
   int n_pass  = 0;

   majority_vote_collector #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .vote_valid(vote_valid), .vote_id(vote_id),
      .vote_val(vote_val), .vote_ready(vote_ready), .x(x), .maj_z(maj_z),
      .result_valid(result_valid), .result(result), .result_ready(result_ready),
      .timed_out(timed_out), .dup_err(dup_err), .id_err(id_err)
   );

   // Downstream 5-input majority circuit.
   assign maj_z = ($countones(x) >= 3);

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vv;
      logic [2:0]  id;
      logic        vl;
      logic        rr;
      logic [10:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   // Packed expectation: {x, vote_ready, result_valid, result, timed_out, dup_err, id_err}
   function automatic logic [10:0] e(input logic [4:0] ex, input logic vr, input logic rv,
                                     input logic res, input logic to, input logic dup,
                                     input logic ide);
      return {ex, vr, rv, res, to, dup, ide};
   endfunction

   task automatic add(input logic r, input logic vv, input logic [2:0] id, input logic vl,
                      input logic rr, input logic [10:0] ex, input string name);
      vec_t v;
      v.rst = r; v.vv = vv; v.id = id; v.vl = vl; v.rr = rr; v.exp = ex; v.name = name;
      tbl.push_back(v);
   endtask

   task automatic step(input logic r, input logic vv, input logic [2:0] id, input logic vl,
                       input logic rr);
      rst = r; vote_valid = vv; vote_id = id; vote_val = vl; result_ready = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [10:0] ex);
      logic [10:0] got;
      got = {x, vote_ready, result_valid, result, timed_out, dup_err, id_err};
      n_total++;
      if (got === ex) n_pass++;
      else $display("FAIL %s: got {x,vr,rv,res,to,dup,ide}=%b expected %b", name, got, ex);
   endtask

   initial begin
      // Reset, illegal ids in IDLE, full in-order round with majority 1.
      add(1, 0, 0, 0, 0, e(5'b00000, 1, 0, 0, 0, 0, 0), "reset_state");
      add(0, 1, 0, 1, 1, e(5'b00000, 1, 0, 0, 0, 0, 1), "idle_id0");
      add(0, 1, 7, 1, 1, e(5'b00000, 1, 0, 0, 0, 0, 1), "idle_id7");
      add(0, 1, 1, 1, 1, e(5'b00001, 1, 0, 0, 0, 0, 0), "a_v1");
      add(0, 1, 2, 1, 1, e(5'b00011, 1, 0, 0, 0, 0, 0), "a_v2");
      add(0, 1, 3, 0, 1, e(5'b00011, 1, 0, 0, 0, 0, 0), "a_v3");
      add(0, 1, 4, 0, 1, e(5'b00011, 1, 0, 0, 0, 0, 0), "a_v4");
      add(0, 1, 5, 1, 1, e(5'b10011, 1, 0, 0, 0, 0, 0), "a_v5");
      add(0, 0, 0, 0, 1, e(5'b10011, 0, 0, 0, 0, 0, 0), "a_to_eval");
      add(0, 0, 0, 0, 1, e(5'b10011, 0, 1, 1, 0, 0, 0), "a_result");
      add(0, 0, 0, 0, 1, e(5'b00000, 1, 0, 1, 0, 0, 0), "a_release");
      // Duplicate voter and illegal id in COLLECT.
      add(0, 1, 3, 1, 1, e(5'b00100, 1, 0, 1, 0, 0, 0), "b_v3");
      add(0, 1, 3, 0, 1, e(5'b00100, 1, 0, 1, 0, 1, 0), "b_dup");
      add(0, 1, 6, 1, 1, e(5'b00100, 1, 0, 1, 0, 0, 1), "b_id6");
      add(0, 0, 0, 0, 1, e(5'b00100, 1, 0, 1, 0, 0, 0), "b_quiet");
      add(1, 0, 0, 0, 0, e(5'b00000, 1, 0, 0, 0, 0, 0), "b_reset");
      // Reset mid-collect, then an out-of-order round with majority 0.
      add(0, 1, 1, 0, 0, e(5'b00000, 1, 0, 0, 0, 0, 0), "c_v1");
      add(0, 1, 2, 1, 0, e(5'b00010, 1, 0, 0, 0, 0, 0), "c_v2");
      add(0, 1, 3, 1, 0, e(5'b00110, 1, 0, 0, 0, 0, 0), "c_v3");
      add(1, 1, 4, 1, 0, e(5'b00000, 1, 0, 0, 0, 0, 0), "c_rst_mid");
      add(0, 1, 5, 0, 0, e(5'b00000, 1, 0, 0, 0, 0, 0), "d_v5");
      add(0, 1, 4, 1, 0, e(5'b01000, 1, 0, 0, 0, 0, 0), "d_v4");
      add(0, 1, 3, 0, 0, e(5'b01000, 1, 0, 0, 0, 0, 0), "d_v3");
      add(0, 1, 2, 0, 0, e(5'b01000, 1, 0, 0, 0, 0, 0), "d_v2");
      add(0, 1, 1, 1, 0, e(5'b01001, 1, 0, 0, 0, 0, 0), "d_v1");
      add(0, 1, 2, 1, 0, e(5'b01001, 0, 0, 0, 0, 1, 0), "d_dup_full");
      add(0, 0, 0, 0, 0, e(5'b01001, 0, 1, 0, 0, 0, 0), "d_result");
      // Stalled consumer with votes offered in HOLD.
      for (int i = 0; i < 10; i++)
         add(0, 1, 3, 1, 0, e(5'b01001, 0, 1, 0, 0, 0, 0), $sformatf("hold_%0d", i));
      add(0, 1, 3, 1, 1, e(5'b00000, 1, 0, 0, 0, 0, 0), "hold_exit");
      add(0, 0, 0, 0, 0, e(5'b00000, 1, 0, 0, 0, 0, 0), "hold_idle");

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].vv, tbl[i].id, tbl[i].vl, tbl[i].rr);
         check(tbl[i].name, tbl[i].exp);
      end

      // Timeout with only voters 2 and 4 reporting.
      step(1, 0, 0, 0, 0);
      step(0, 1, 2, 1, 0);
      check("t_v2", e(5'b00010, 1, 0, 0, 0, 0, 0));
      step(0, 1, 4, 1, 0);
      check("t_v4", e(5'b01010, 1, 0, 0, 0, 0, 0));
      for (int i = 2; i <= 15; i++) begin
         step(0, 0, 0, 0, 0);
         check($sformatf("t_wait_%0d", i), e(5'b01010, 1, 0, 0, 0, 0, 0));
      end
      step(0, 0, 0, 0, 0);
      check("t_expire", e(5'b01010, 0, 0, 0, 1, 0, 0));
      step(0, 0, 0, 0, 0);
      check("t_result", e(5'b01010, 0, 1, 0, 1, 0, 0));
      step(0, 1, 1, 1, 0);
      check("t_hold", e(5'b01010, 0, 1, 0, 1, 0, 0));
      step(1, 0, 0, 0, 0);
      check("t_rst_hold", e(5'b00000, 1, 0, 0, 0, 0, 0));

      // Fifth vote lands on the last timer cycle: completion beats timeout.
      step(0, 1, 1, 1, 0);
      step(0, 1, 2, 1, 0);
      step(0, 1, 3, 1, 0);
      step(0, 1, 4, 0, 0);
      check("r_four", e(5'b00111, 1, 0, 0, 0, 0, 0));
      for (int i = 4; i <= 15; i++) begin
         step(0, 0, 0, 0, 0);
         check($sformatf("r_wait_%0d", i), e(5'b00111, 1, 0, 0, 0, 0, 0));
      end
      step(0, 1, 5, 1, 0);
      check("r_last_vote", e(5'b10111, 1, 0, 0, 0, 0, 0));
      step(0, 0, 0, 0, 0);
      check("r_eval", e(5'b10111, 0, 0, 0, 0, 0, 0));
      step(0, 0, 0, 0, 0);
      check("r_result", e(5'b10111, 0, 1, 1, 0, 0, 0));
      step(0, 0, 0, 0, 1);
      check("r_release", e(5'b00000, 1, 0, 1, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
